// File: rtl/lane_score_keeper_pkg.sv
// Shared definitions for the lane score keeper.
// Judge encodings and default point values.
package lane_score_keeper_pkg;

  typedef enum logic [1:0] {
    J_NONE   = 2'b00,
    J_PLUS1  = 2'b01,
    J_PLUS2  = 2'b10,
    J_MINUS2 = 2'b11
  } judge_e;

  localparam int PERFECT_PTS_D = 2;
  localparam int GOOD_PTS_D    = 1;
  localparam int MISS_PTS_D    = 2;

endpackage

// File: rtl/lane_score_keeper_if.sv
// Lane inputs and score outputs bundled for
// the score keeper and its producer/consumer.
interface lane_score_keeper_if #(
  parameter int LANES   = 4,
  parameter int SCORE_W = 10,
  parameter int COMBO_W = 6
);

  logic [LANES-1:0]   key;
  logic [LANES-1:0]   OlightOn;
  logic [LANES-1:0]   lastGlightOn;
  logic               hold;
  logic               clear;
  logic [LANES-1:0]   add1;
  logic [LANES-1:0]   add2;
  logic [LANES-1:0]   sub2;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;

  modport master (
    output key, OlightOn, lastGlightOn,
    output hold, clear,
    input  add1, add2, sub2,
    input  score, combo
  );

  modport slave (
    input  key, OlightOn, lastGlightOn,
    input  hold, clear,
    output add1, add2, sub2,
    output score, combo
  );

endinterface

// File: rtl/lane_score_keeper_judge.sv
// Per-lane press edge detect and judgement
// register with one-hot flag decode.
module lane_judge
  import lane_score_keeper_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   key,
  input  logic   olight,
  input  logic   glight,
  input  logic   hold,
  input  logic   clear,
  output judge_e judge_d,
  output logic   add1,
  output logic   add2,
  output logic   sub2
);

  logic   key_q;
  logic   press;
  judge_e judge_q;

  assign press = key & ~key_q;

  always_comb begin
    judge_d = J_NONE;
    if (press && !hold && !clear) begin
      if (olight)      judge_d = J_PLUS2;
      else if (glight) judge_d = J_PLUS1;
      else             judge_d = J_MINUS2;
    end
  end

  // key_q tracks key even in hold so a held key never scores later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 1'b0;
      judge_q <= J_NONE;
    end else begin
      key_q   <= key;
      judge_q <= judge_d;
    end
  end

  assign add1 = (judge_q == J_PLUS1);
  assign add2 = (judge_q == J_PLUS2);
  assign sub2 = (judge_q == J_MINUS2);

endmodule

// File: rtl/lane_score_keeper.sv
// Multi-lane score keeper: judges all lanes,
// sums points, keeps saturating score and combo.
module lane_score_keeper
  import lane_score_keeper_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int SCORE_W        = 10,
  parameter int PERFECT_PTS    = PERFECT_PTS_D,
  parameter int GOOD_PTS       = GOOD_PTS_D,
  parameter int MISS_PTS       = MISS_PTS_D,
  parameter int COMBO_W        = 6,
  parameter int COMBO_BONUS_AT = 8
) (
  input logic clk,
  input logic rst,
  lane_score_keeper_if.slave bus
);

  localparam int NW  = $clog2(LANES + 1);
  localparam int DW  = SCORE_W + 2 + $clog2(LANES);
  localparam int CXW = COMBO_W + 4;

  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [COMBO_W-1:0] CMAX = '1;
  localparam logic [COMBO_W-1:0] BONUS_AT =
    COMBO_W'(COMBO_BONUS_AT);

  localparam logic signed [DW-1:0] PP = DW'(PERFECT_PTS);
  localparam logic signed [DW-1:0] GP = DW'(GOOD_PTS);
  localparam logic signed [DW-1:0] MP = DW'(MISS_PTS);
  localparam logic signed [DW-1:0] SMAX_S = DW'(SMAX);

  judge_e             jd [LANES];
  logic [LANES-1:0]   add1_v, add2_v, sub2_v;
  logic [NW-1:0]      np, ng, nm;
  logic [CXW-1:0]     csum;
  logic [COMBO_W-1:0] combo_d, combo_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic               bonus_on;
  logic signed [DW-1:0] np_s, ng_s, nm_s;
  logic signed [DW-1:0] delta, sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_judge u_judge (
      .clk     (clk),
      .rst     (rst),
      .key     (bus.key[i]),
      .olight  (bus.OlightOn[i]),
      .glight  (bus.lastGlightOn[i]),
      .hold    (bus.hold),
      .clear   (bus.clear),
      .judge_d (jd[i]),
      .add1    (add1_v[i]),
      .add2    (add2_v[i]),
      .sub2    (sub2_v[i])
    );
  end

  always_comb begin
    np = '0;
    ng = '0;
    nm = '0;
    for (int i = 0; i < LANES; i++) begin
      np = np + NW'(jd[i] == J_PLUS2);
      ng = ng + NW'(jd[i] == J_PLUS1);
      nm = nm + NW'(jd[i] == J_MINUS2);
    end
  end

  always_comb begin
    csum = CXW'(combo_q) + CXW'(np) + CXW'(ng);
    if (|nm)
      combo_d = '0;
    else if (csum > CXW'(CMAX))
      combo_d = CMAX;
    else
      combo_d = csum[COMBO_W-1:0];
  end

  // signed sum wide enough that clamping sees the true value
  always_comb begin
    np_s     = $signed(DW'(np));
    ng_s     = $signed(DW'(ng));
    nm_s     = $signed(DW'(nm));
    bonus_on = ~|nm && (combo_d >= BONUS_AT);
    delta    = PP * np_s + GP * ng_s - MP * nm_s;
    if (bonus_on)
      delta = delta + np_s + ng_s;
    sum = $signed(DW'(score_q)) + delta;
    if (sum[DW-1])
      score_d = '0;
    else if (sum > SMAX_S)
      score_d = SMAX;
    else
      score_d = sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      combo_q <= '0;
    end else if (bus.clear) begin
      score_q <= '0;
      combo_q <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign bus.add1  = add1_v;
  assign bus.add2  = add2_v;
  assign bus.sub2  = sub2_v;
  assign bus.score = score_q;
  assign bus.combo = combo_q;

endmodule

// File: tb/tb_lane_score_keeper.sv
// Directed bench for lane_score_keeper with
// hand-computed expected score/combo/flags.
module tb_lane_score_keeper;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  lane_score_keeper_if bus ();

  lane_score_keeper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_sc(input string tag,
                        input int s, input int c);
    chk({tag, ".score"}, 32'(bus.score), s);
    chk({tag, ".combo"}, 32'(bus.combo), c);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k,
                       input logic [3:0] o,
                       input logic [3:0] g);
    bus.key          = k;
    bus.OlightOn     = o;
    bus.lastGlightOn = g;
    step();
  endtask

  task automatic rel;
    drive(4'h0, 4'h0, 4'h0);
  endtask

  task automatic hit(input logic [3:0] k,
                     input logic [3:0] o,
                     input logic [3:0] g);
    drive(k, o, g);
    rel();
  endtask

  initial begin
    rst              = 1'b1;
    bus.hold         = 1'b0;
    bus.clear        = 1'b0;
    bus.key          = '0;
    bus.OlightOn     = '0;
    bus.lastGlightOn = '0;
    step();
    step();
    chk_sc("rst", 0, 0);
    chk("rst.add1", 32'(bus.add1), 0);
    chk("rst.add2", 32'(bus.add2), 0);
    chk("rst.sub2", 32'(bus.sub2), 0);
    rst = 1'b0;
    step();

    // build score 37 / combo 5
    repeat (3) hit(4'hF, 4'hF, 4'h0);
    chk_sc("allp3", 32, 12);
    hit(4'h1, 4'h0, 4'h0);
    chk_sc("miss0", 30, 0);
    repeat (2) hit(4'h1, 4'h1, 4'h0);
    repeat (2) hit(4'h1, 4'h0, 4'h1);
    drive(4'h1, 4'h0, 4'h1);
    chk_sc("pre_rst", 37, 5);
    chk("pre_rst.add1", 32'(bus.add1), 1);
    #2;
    rst              = 1'b1;
    bus.key          = '0;
    bus.OlightOn     = '0;
    bus.lastGlightOn = '0;
    #1;
    chk_sc("async_rst", 0, 0);
    chk("async_rst.add1", 32'(bus.add1), 0);
    step();
    rst = 1'b0;
    step();

    drive(4'h1, 4'h1, 4'h0);
    chk("t2.add2", 32'(bus.add2), 1);
    chk_sc("t2", 2, 1);
    step();
    chk("t2.add2_pulse", 32'(bus.add2), 0);
    repeat (4) step();
    chk_sc("t2.held", 2, 1);
    rel();

    hit(4'hF, 4'hF, 4'h0);
    chk_sc("t3.pre", 10, 5);
    drive(4'b0111, 4'b0001, 4'b0010);
    chk("t3.add2", 32'(bus.add2), 1);
    chk("t3.add1", 32'(bus.add1), 2);
    chk("t3.sub2", 32'(bus.sub2), 4);
    chk_sc("t3", 11, 0);
    rel();

    hit(4'hF, 4'h0, 4'h0);
    hit(4'h1, 4'h0, 4'h0);
    chk_sc("t4.pre", 1, 0);
    drive(4'hF, 4'h0, 4'h0);
    chk("t4.sub2", 32'(bus.sub2), 15);
    chk_sc("t4.low", 0, 0);
    rel();

    repeat (84) hit(4'hF, 4'hF, 4'h0);
    chk_sc("t4.climb", 1004, 63);
    hit(4'hF, 4'b0111, 4'h0);
    hit(4'hF, 4'hF, 4'h0);
    hit(4'hF, 4'b0111, 4'h0);
    hit(4'b0111, 4'b0011, 4'h0);
    chk_sc("t4.1022", 1022, 0);
    hit(4'h1, 4'h1, 4'h0);
    chk_sc("t4.1023", 1023, 1);
    hit(4'h1, 4'h1, 4'h0);
    chk_sc("t4.sat", 1023, 2);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk_sc("t5.rst", 0, 0);
    repeat (7) hit(4'hF, 4'hF, 4'h0);
    chk_sc("t5.a", 80, 28);
    hit(4'hF, 4'b0111, 4'h0);
    hit(4'b0111, 4'b0011, 4'h0);
    repeat (7) hit(4'h1, 4'h1, 4'h0);
    chk_sc("t5.pre", 100, 7);
    drive(4'h8, 4'h8, 4'h0);
    chk("t5.add2", 32'(bus.add2), 8);
    chk_sc("t5.bonus", 103, 8);
    rel();
    repeat (14) hit(4'hF, 4'hF, 4'h0);
    chk_sc("t5.cmax", 271, 63);
    drive(4'h1, 4'h0, 4'h1);
    chk("t5.add1", 32'(bus.add1), 1);
    chk_sc("t5.csat", 273, 63);
    rel();

    bus.hold = 1'b1;
    drive(4'h2, 4'h2, 4'h0);
    chk("t6.hold_add2", 32'(bus.add2), 0);
    chk_sc("t6.hold", 273, 63);
    bus.hold = 1'b0;
    step();
    chk("t6.after_add2", 32'(bus.add2), 0);
    chk_sc("t6.after", 273, 63);
    rel();
    bus.clear = 1'b1;
    drive(4'h1, 4'h1, 4'h0);
    chk("t6.clr_add2", 32'(bus.add2), 0);
    chk_sc("t6.clr", 0, 0);
    bus.clear = 1'b0;
    rel();
    drive(4'h1, 4'h1, 4'h0);
    chk("t6.resume_add2", 32'(bus.add2), 1);
    chk_sc("t6.resume", 2, 1);
    rel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
